// File: rtl/axi_paillier_slave.sv
// AXI4 slave register front-end for the modular-exponentiation core.
// Operand words shift in through DATA; CTRL starts the core, STATUS/DATA read back results.
module axi_paillier_slave #(
  parameter int WIDTH_ID = 4,
  parameter int WIDTH_AD = 32,
  parameter int WIDTH_OP = 2048
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [WIDTH_ID-1:0] AWID,
  input  logic [WIDTH_AD-1:0] AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [31:0]         WDATA,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [WIDTH_ID-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [WIDTH_ID-1:0] ARID,
  input  logic [WIDTH_AD-1:0] ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [WIDTH_ID-1:0] RID,
  output logic [31:0]         RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  output logic                core_start,
  output logic [WIDTH_OP-1:0] core_operand,
  input  logic                core_done,
  input  logic [WIDTH_OP-1:0] core_result
);
  localparam int NW = WIDTH_OP / 32;
  localparam int PW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_STAT = 8'h04;
  localparam logic [7:0] A_DATA = 8'h10;

  typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_ADDR, R_DATA} rstate_t;

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;

  logic [7:0]           waddr, wlen, wcnt;
  logic [7:0]           raddr, rlen, rcnt;
  logic                 busy, done;
  logic [NW-1:0][31:0]  result;
  logic [PW-1:0]        rd_ptr, rd_ptr_nxt;
  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                 start_fire;
  logic                 unused_ok;

  assign unused_ok = ^{AWADDR[WIDTH_AD-1:8], ARADDR[WIDTH_AD-1:8]};

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // A start needs an idle core; a coincident core_done always wins.
  assign start_fire = w_hs && (waddr == A_CTRL) && (WDATA != 32'd0) && !busy && !core_done;

  function automatic logic addr_ok(input logic [7:0] a);
    return (a == A_CTRL) || (a == A_STAT) || (a == A_DATA);
  endfunction

  function automatic logic [31:0] rd_word(input logic [7:0] a, input logic [PW-1:0] p);
    case (a)
      A_CTRL:  rd_word = {31'b0, busy};
      A_STAT:  rd_word = {31'b0, done};
      A_DATA:  rd_word = result[p];
      default: rd_word = 32'd0;
    endcase
  endfunction

  always_comb begin
    wnext = wstate;
    case (wstate)
      W_ADDR:  if (aw_hs) wnext = W_DATA;
      W_DATA:  if (w_hs && (wcnt == wlen)) wnext = W_RESP;
      W_RESP:  if (b_hs) wnext = W_ADDR;
      default: wnext = W_ADDR;
    endcase
  end

  always_comb begin
    rnext = rstate;
    case (rstate)
      R_ADDR:  if (ar_hs) rnext = R_DATA;
      R_DATA:  if (r_hs && RLAST) rnext = R_ADDR;
      default: rnext = R_ADDR;
    endcase
  end

  // Start clears the read pointer even if a DATA beat is accepted the same cycle.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (start_fire)
      rd_ptr_nxt = '0;
    else if (r_hs && (raddr == A_DATA))
      rd_ptr_nxt = (rd_ptr == PW'(NW-1)) ? '0 : rd_ptr + 1'b1;
  end

  // Handshake readies/valid are registered copies of the next state.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate  <= W_ADDR;
      rstate  <= R_ADDR;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      ARREADY <= 1'b0;
    end else begin
      wstate  <= wnext;
      rstate  <= rnext;
      AWREADY <= (wnext == W_ADDR);
      WREADY  <= (wnext == W_DATA);
      BVALID  <= (wnext == W_RESP);
      ARREADY <= (rnext == R_ADDR);
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      BID   <= '0;
      BRESP <= 2'b00;
      waddr <= '0;
      wlen  <= '0;
      wcnt  <= '0;
    end else begin
      if (aw_hs) begin
        BID   <= AWID;
        waddr <= AWADDR[7:0];
        wlen  <= AWLEN;
        wcnt  <= '0;
        BRESP <= addr_ok(AWADDR[7:0]) ? 2'b00 : 2'b10;
      end
      if (w_hs) wcnt <= wcnt + 8'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      core_start   <= 1'b0;
      core_operand <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
    end else begin
      core_start <= start_fire;
      if (w_hs && (waddr == A_DATA))
        core_operand <= {WDATA, core_operand[WIDTH_OP-1:32]};
      if (core_done) begin
        busy   <= 1'b0;
        done   <= 1'b1;
        result <= core_result;
      end else if (start_fire) begin
        busy <= 1'b1;
        done <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      RID    <= '0;
      RDATA  <= '0;
      RRESP  <= 2'b00;
      RLAST  <= 1'b0;
      RVALID <= 1'b0;
      raddr  <= '0;
      rlen   <= '0;
      rcnt   <= '0;
      rd_ptr <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (ar_hs) begin
        RID    <= ARID;
        raddr  <= ARADDR[7:0];
        rlen   <= ARLEN;
        rcnt   <= '0;
        RVALID <= 1'b1;
        RDATA  <= rd_word(ARADDR[7:0], rd_ptr_nxt);
        RRESP  <= addr_ok(ARADDR[7:0]) ? 2'b00 : 2'b10;
        RLAST  <= (ARLEN == 8'd0);
      end else if (r_hs) begin
        if (RLAST) begin
          RVALID <= 1'b0;
          RLAST  <= 1'b0;
        end else begin
          rcnt  <= rcnt + 8'd1;
          RDATA <= rd_word(raddr, rd_ptr_nxt);
          RLAST <= (rcnt + 8'd1 == rlen);
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_paillier_slave.sv
// Directed bench for axi_paillier_slave: operand load, start/status, result readback,
// error decode, read stall and mid-burst reset.
module tb_axi_paillier_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        core_start, core_done;
  logic [2047:0] core_operand, core_result;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  logic [31:0] rd_data [0:15];
  logic [1:0]  rd_resp [0:15];
  logic [15:0] rd_last;

  always #5 clk = ~clk;
  always @(posedge clk) if (core_start) start_cnt++;

  axi_paillier_slave dut (
    .ACLK(clk), .ARESET(rst),
    .AWID(awid), .AWADDR(awaddr), .AWLEN(awlen), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WVALID(wvalid), .WREADY(wready),
    .BID(bid), .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
    .ARID(arid), .ARADDR(araddr), .ARLEN(arlen), .ARVALID(arvalid), .ARREADY(arready),
    .RID(rid), .RDATA(rdata), .RRESP(rresp), .RLAST(rlast), .RVALID(rvalid), .RREADY(rready),
    .core_start(core_start), .core_operand(core_operand),
    .core_done(core_done), .core_result(core_result)
  );

  task automatic timeout(input string what);
    checks++; failures++;
    $display("FAIL timeout_%s: handshake not seen within 100 cycles", what);
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [7:0] len, input logic [31:0] d0,
                           input logic [3:0] id, output logic [1:0] resp, output logic [3:0] rid_o);
    int t;
    resp = 2'bxx; rid_o = 4'hx;
    @(negedge clk);
    awid = id; awaddr = {24'h0, addr}; awlen = len; awvalid = 1'b1;
    t = 0; while (!awready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin timeout("aw"); awvalid = 1'b0; return; end
    @(negedge clk); awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      wdata = d0 + k; wvalid = 1'b1;
      t = 0; while (!wready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin timeout("w"); wvalid = 1'b0; return; end
      @(negedge clk);
    end
    wvalid = 1'b0; bready = 1'b1;
    t = 0; while (!bvalid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin timeout("b"); bready = 1'b0; return; end
    resp = bresp; rid_o = bid;
    @(negedge clk); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, input logic [7:0] len);
    int t;
    rd_last = '0;
    @(negedge clk);
    arid = 4'h3; araddr = {24'h0, addr}; arlen = len; arvalid = 1'b1;
    t = 0; while (!arready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin timeout("ar"); arvalid = 1'b0; return; end
    @(negedge clk); arvalid = 1'b0; rready = 1'b1;
    for (int k = 0; k <= int'(len); k++) begin
      t = 0; while (!rvalid && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin timeout("r"); rready = 1'b0; return; end
      rd_data[k] = rdata; rd_resp[k] = rresp; rd_last[k] = rlast;
      @(negedge clk);
    end
    rready = 1'b0;
  endtask

  task automatic pulse_done(input logic [31:0] base);
    @(negedge clk);
    for (int k = 0; k < 64; k++) core_result[k*32 +: 32] = base + k;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast, core_start} !== 7'b0) begin
      failures++; $display("FAIL reset_ctl: got %b expected 0000000",
        {awready, wready, bvalid, arready, rvalid, rlast, core_start});
    end
    checks++;
    if (core_operand !== 2048'd0) begin failures++; $display("FAIL reset_operand: not zero"); end
    checks++;
    if ({bid, bresp, rid, rresp, rdata} !== 44'd0) begin
      failures++; $display("FAIL reset_resp: got %h expected 0", {bid, bresp, rid, rresp, rdata});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b101) begin
      failures++; $display("FAIL ready_after_reset: got %b expected 101", {awready, wready, arready});
    end
  endtask

  task automatic test_operand_load;
    logic [1:0] r; logic [3:0] b; int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      axi_write(8'h10, 8'd0, i + 1, 4'h5, r, b);
      if (r !== 2'b00 || b !== 4'h5) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL load_bresp: %0d bad responses expected 0", bad); end
    checks++;
    if (core_operand[31:0] !== 32'd1) begin
      failures++; $display("FAIL operand_lsw: got %h expected 1", core_operand[31:0]);
    end
    checks++;
    if (core_operand[63:32] !== 32'd2) begin
      failures++; $display("FAIL operand_w1: got %h expected 2", core_operand[63:32]);
    end
    checks++;
    if (core_operand[2047:2016] !== 32'd64) begin
      failures++; $display("FAIL operand_msw: got %h expected 40", core_operand[2047:2016]);
    end
    axi_write(8'h00, 8'd0, 32'hFFFF_FFFF, 4'h9, r, b);
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt != 1 || r !== 2'b00 || b !== 4'h9) begin
      failures++; $display("FAIL ctrl_start: starts=%0d resp=%b bid=%h expected 1/00/9", start_cnt, r, b);
    end
  endtask

  task automatic test_status;
    axi_read(8'h04, 8'd0);
    checks++;
    if (rd_data[0] !== 32'd0 || rd_resp[0] !== 2'b00) begin
      failures++; $display("FAIL status_busy: got %h/%b expected 0/00", rd_data[0], rd_resp[0]);
    end
    axi_read(8'h00, 8'd0);
    checks++;
    if (rd_data[0] !== 32'd1) begin failures++; $display("FAIL ctrl_busy: got %h expected 1", rd_data[0]); end
    pulse_done(32'd0);
    axi_read(8'h04, 8'd0);
    checks++;
    if (rd_data[0] !== 32'd1) begin failures++; $display("FAIL status_done: got %h expected 1", rd_data[0]); end
    axi_read(8'h00, 8'd0);
    checks++;
    if (rd_data[0] !== 32'd0) begin failures++; $display("FAIL ctrl_idle: got %h expected 0", rd_data[0]); end
  endtask

  task automatic test_burst_read;
    axi_read(8'h10, 8'd3);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rd_data[k] !== k || rd_resp[k] !== 2'b00) begin
        failures++; $display("FAIL burst_beat%0d: got %h/%b expected %h/00", k, rd_data[k], rd_resp[k], k);
      end
    end
    checks++;
    if (rd_last[3:0] !== 4'b1000) begin
      failures++; $display("FAIL burst_rlast: got %b expected 1000", rd_last[3:0]);
    end
    // Pointer now at 4; 60 singles reach word 63, the next wraps to 0.
    for (int k = 4; k < 64; k++) axi_read(8'h10, 8'd0);
    checks++;
    if (rd_data[0] !== 32'd63 || rd_last[0] !== 1'b1) begin
      failures++; $display("FAIL read_w63: got %h last=%b expected 3f/1", rd_data[0], rd_last[0]);
    end
    axi_read(8'h10, 8'd0);
    checks++;
    if (rd_data[0] !== 32'd0) begin failures++; $display("FAIL read_wrap: got %h expected 0", rd_data[0]); end
  endtask

  task automatic test_error;
    logic [1:0] r; logic [3:0] b;
    axi_write(8'h20, 8'd1, 32'h1234, 4'h2, r, b);
    checks++;
    if (r !== 2'b10) begin failures++; $display("FAIL bad_wr_resp: got %b expected 10", r); end
    axi_read(8'h20, 8'd0);
    checks++;
    if (rd_resp[0] !== 2'b10 || rd_data[0] !== 32'd0) begin
      failures++; $display("FAIL bad_rd: got %h/%b expected 0/10", rd_data[0], rd_resp[0]);
    end
    axi_write(8'h04, 8'd0, 32'h1, 4'h2, r, b);
    checks++;
    if (r !== 2'b00) begin failures++; $display("FAIL status_wr_resp: got %b expected 00", r); end
    axi_write(8'h00, 8'd0, 32'h1, 4'h2, r, b);
    repeat (2) @(negedge clk);
    checks++;
    if (start_cnt != 2) begin failures++; $display("FAIL second_start: starts=%0d expected 2", start_cnt); end
    axi_write(8'h00, 8'd0, 32'h1, 4'h2, r, b);
    repeat (2) @(negedge clk);
    checks++;
    if (start_cnt != 2 || r !== 2'b00) begin
      failures++; $display("FAIL start_busy: starts=%0d resp=%b expected 2/00", start_cnt, r);
    end
    axi_read(8'h04, 8'd0);
    checks++;
    if (rd_data[0] !== 32'd0) begin failures++; $display("FAIL done_cleared: got %h expected 0", rd_data[0]); end
  endtask

  task automatic test_rready_stall;
    int t;
    pulse_done(32'h100);
    @(negedge clk);
    araddr = 32'h10; arlen = 8'd2; arid = 4'h7; arvalid = 1'b1;
    t = 0; while (!arready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin timeout("stall_ar"); arvalid = 1'b0; return; end
    @(negedge clk); arvalid = 1'b0; rready = 1'b1;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h100 || rid !== 4'h7) begin
      failures++; $display("FAIL stall_beat0: got v=%b %h id=%h expected 1 100 7", rvalid, rdata, rid);
    end
    @(negedge clk); rready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== 32'h101 || rlast !== 1'b0) begin
        failures++; $display("FAIL stall_hold%0d: got v=%b %h l=%b expected 1 101 0", c, rvalid, rdata, rlast);
      end
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h102 || rlast !== 1'b1) begin
      failures++; $display("FAIL stall_beat2: got v=%b %h l=%b expected 1 102 1", rvalid, rdata, rlast);
    end
    @(negedge clk); rready = 1'b0;
    axi_read(8'h10, 8'd0);
    checks++;
    if (rd_data[0] !== 32'h103) begin failures++; $display("FAIL stall_ptr: got %h expected 103", rd_data[0]); end
  endtask

  task automatic test_reset_burst;
    int t; logic [1:0] r; logic [3:0] b;
    @(negedge clk);
    awaddr = 32'h10; awlen = 8'd7; awid = 4'h1; awvalid = 1'b1;
    t = 0; while (!awready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin timeout("rst_aw"); awvalid = 1'b0; return; end
    @(negedge clk); awvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wdata = 32'hA0 + k; wvalid = 1'b1;
      t = 0; while (!wready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin timeout("rst_w"); wvalid = 1'b0; return; end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wready !== 1'b0 || bvalid !== 1'b0 || core_operand !== 2048'd0) begin
      failures++; $display("FAIL midburst_reset: wready=%b bvalid=%b operand_lsw=%h expected 0 0 0",
        wready, bvalid, core_operand[31:0]);
    end
    rst = 1'b0; wvalid = 1'b0;
    axi_write(8'h10, 8'd0, 32'hABCD, 4'h6, r, b);
    checks++;
    if (r !== 2'b00 || b !== 4'h6 || core_operand[2047:2016] !== 32'hABCD) begin
      failures++; $display("FAIL post_reset_wr: resp=%b bid=%h msw=%h expected 00 6 abcd",
        r, b, core_operand[2047:2016]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    core_done = 1'b0; core_result = '0;
    test_reset();
    test_operand_load();
    test_status();
    test_burst_read();
    test_error();
    test_rready_stall();
    test_reset_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
